// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Request / write / read channel bundle between an accelerator initiator and
//   the mem_responder SRAM model.
//
//   Parameters : MEM_LEN_BITS, MEM_ADDR_BITS, MEM_DATA_BITS (field widths)
//   Signals    : mem_req_valid/opcode/len/addr  request strobe and descriptor
//                mem_wr_valid/bits              write beat channel
//                mem_rd_valid/bits/ready        read beat channel (valid/ready)
//   Modports   : master - initiator side, slave - responder side
// -----------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
);
  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;

  modport master (
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready,
    input  mem_rd_valid, mem_rd_bits
  );

  modport slave (
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
    output mem_rd_valid, mem_rd_bits
  );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder with an internal word-addressed SRAM. Services one
//   read or write burst at a time. Reads return the first beat RD_LATENCY
//   cycles after the request is accepted and then stream one word per
//   handshake; writes accept one beat per cycle that mem_wr_valid is high.
//
//   Ports : clock, reset_n (async, active-low)
//           mem    - mem_responder_if.slave (request, write and read channels)
//           busy   - high while a request is in service
//           err    - sticky protocol error (request while busy, stray write)
//           stat_rd_beats / stat_wr_beats - only with MEM_RESPONDER_STATS_EN
//
//   Build option: define MEM_RESPONDER_STATS_EN to add 32-bit counters of
//   completed read handshakes and accepted write beats.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_WORDS   = 256,
  parameter int RD_LATENCY    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_responder_if.slave     mem,
  output logic               busy,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [31:0]        stat_rd_beats,
  output logic [31:0]        stat_wr_beats,
`endif
  output logic               err
);

  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  localparam int LAT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA} state_t;

  state_t                   state;
  logic [IDX_BITS-1:0]      idx;
  logic [IDX_BITS-1:0]      idx_next;
  logic [MEM_LEN_BITS-1:0]  len_q;
  // One bit wider than the length field so a maximum burst cannot overflow.
  logic [MEM_LEN_BITS:0]    beat_cnt;
  logic [LAT_BITS-1:0]      lat_cnt;
  logic                     last_beat;
  logic                     wr_fire;
  logic [MEM_DATA_BITS-1:0] sram [DEPTH_WORDS];

  // Only the word-index bits of the address select a location.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem.mem_req_addr[MEM_ADDR_BITS-1:IDX_BITS+3],
                              mem.mem_req_addr[2:0]};

  assign idx_next  = idx + 1'b1;   // wraps modulo DEPTH_WORDS
  assign last_beat = (beat_cnt == {1'b0, len_q});
  assign wr_fire   = (state == WR_DATA) && mem.mem_wr_valid;

  // NOTE: the SRAM array lives in its own clocked block with no reset, so it
  // maps onto a memory macro; resetting it would force a flop array.
  always_ff @(posedge clock) begin
    if (wr_fire) sram[idx] <= mem.mem_wr_bits;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      idx              <= '0;
      len_q            <= '0;
      beat_cnt         <= '0;
      lat_cnt          <= '0;
      mem.mem_rd_valid <= 1'b0;
      mem.mem_rd_bits  <= '0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      // Requests are dropped unless idle (including the final-beat cycle);
      // write beats outside a write burst are ignored. Both are sticky errors.
      if ((mem.mem_req_valid && state != IDLE) ||
          (mem.mem_wr_valid && state != WR_DATA)) begin
        err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (mem.mem_req_valid) begin
            idx      <= mem.mem_req_addr[IDX_BITS+2:3];
            len_q    <= mem.mem_req_len;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (mem.mem_req_opcode) begin
              state <= WR_DATA;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_BITS'(RD_LATENCY - 1);
            end
          end
        end

        RD_WAIT: begin
          if (lat_cnt == '0) begin
            mem.mem_rd_bits  <= sram[idx];
            mem.mem_rd_valid <= 1'b1;
            state            <= RD_DATA;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        RD_DATA: begin
          // Data is held until the initiator accepts it; the next word is
          // fetched in the handshake cycle so there is no bubble.
          if (mem.mem_rd_ready) begin
            if (last_beat) begin
              mem.mem_rd_valid <= 1'b0;
              busy             <= 1'b0;
              state            <= IDLE;
            end else begin
              idx             <= idx_next;
              beat_cnt        <= beat_cnt + 1'b1;
              mem.mem_rd_bits <= sram[idx_next];
            end
          end
        end

        WR_DATA: begin
          if (mem.mem_wr_valid) begin
            if (last_beat) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx      <= idx_next;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  // Counters wrap naturally at 2^32 and tick in the beat's own cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_beats <= '0;
      stat_wr_beats <= '0;
    end else begin
      if (mem.mem_rd_valid && mem.mem_rd_ready) stat_rd_beats <= stat_rd_beats + 1'b1;
      if (wr_fire)                              stat_wr_beats <= stat_wr_beats + 1'b1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Drives directed and randomized bursts into mem_responder and compares the
//   returned data, timing and status flags against a word-array model of the
//   SRAM plus simple expected counters.
// -----------------------------------------------------------------------------
module tb_mem_responder;
  localparam int LEN_BITS  = 8;
  localparam int ADDR_BITS = 64;
  localparam int DATA_BITS = 64;
  localparam int DEPTH     = 256;
  localparam int RD_LAT    = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic err;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] stat_rd_beats;
  logic [31:0] stat_wr_beats;
`endif

  always #5 clock = ~clock;

  mem_responder_if #(
    .MEM_LEN_BITS (LEN_BITS),
    .MEM_ADDR_BITS(ADDR_BITS),
    .MEM_DATA_BITS(DATA_BITS)
  ) mem ();

  mem_responder #(
    .MEM_LEN_BITS (LEN_BITS),
    .MEM_ADDR_BITS(ADDR_BITS),
    .MEM_DATA_BITS(DATA_BITS),
    .DEPTH_WORDS  (DEPTH),
    .RD_LATENCY   (RD_LAT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem          (mem),
    .busy         (busy),
`ifdef MEM_RESPONDER_STATS_EN
    .stat_rd_beats(stat_rd_beats),
    .stat_wr_beats(stat_wr_beats),
`endif
    .err          (err)
  );

  // Reference state
  logic [63:0] model [DEPTH];
  logic [63:0] wdata_q [$];
  logic        exp_err;
  int          exp_rd;
  int          exp_wr;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [63:0] addr, input int beat);
    return int'(((addr >> 3) + 64'(beat)) % 64'(DEPTH));
  endfunction

  task automatic check_stats();
`ifdef MEM_RESPONDER_STATS_EN
    check("stat_rd_beats", stat_rd_beats, 64'(exp_rd));
    check("stat_wr_beats", stat_wr_beats, 64'(exp_wr));
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) check("idle_timeout", busy, 0);
  endtask

  task automatic do_write(input logic [63:0] addr, input int len, input bit gaps);
    logic [63:0] d;
    @(negedge clock);
    check("wr_pre_busy", busy, 0);
    mem.mem_req_valid  = 1'b1;
    mem.mem_req_opcode = 1'b1;
    mem.mem_req_len    = LEN_BITS'(len);
    mem.mem_req_addr   = addr;
    @(negedge clock);
    mem.mem_req_valid  = 1'b0;
    check("wr_busy", busy, 1);
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      d = (wdata_q.size() != 0) ? wdata_q.pop_front() : {$urandom, $urandom};
      mem.mem_wr_valid = 1'b1;
      mem.mem_wr_bits  = d;
      model[word_of(addr, i)] = d;
      exp_wr++;
      @(negedge clock);
      mem.mem_wr_valid = 1'b0;
    end
    check("wr_done_busy", busy, 0);
    check("wr_err", err, exp_err);
  endtask

  // ready_mode: 0 = always ready, 1 = toggle 1,0,1..., 2 = random
  // inject: 0 = none, 1 = extra request on beat 1, 2 = extra request on final handshake
  task automatic do_read(input logic [63:0] addr, input int len, input int ready_mode,
                         input int inject);
    int  k;
    int  beat;
    int  cyc;
    bit  rdy;
    bit  v;
    bit  injected;
    @(negedge clock);
    check("rd_pre_busy", busy, 0);
    mem.mem_req_valid  = 1'b1;
    mem.mem_req_opcode = 1'b0;
    mem.mem_req_len    = LEN_BITS'(len);
    mem.mem_req_addr   = addr;
    @(negedge clock);
    mem.mem_req_valid  = 1'b0;
    check("rd_valid_early", mem.mem_rd_valid, 0);
    check("rd_busy", busy, 1);
    k = 0;
    while (mem.mem_rd_valid !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("rd_latency", 64'(k), 64'(RD_LAT));
    beat     = 0;
    cyc      = 0;
    injected = 1'b0;
    while (beat <= len && cyc < 4 * (len + 1) + 10) begin
      v = mem.mem_rd_valid;
      check("rd_valid_hold", v, 1);
      check("rd_data", mem.mem_rd_bits, model[word_of(addr, beat)]);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      if (!injected && ((inject == 1 && beat == 1) || (inject == 2 && beat == len && rdy))) begin
        mem.mem_req_valid  = 1'b1;
        mem.mem_req_opcode = 1'b1;
        mem.mem_req_len    = '0;
        mem.mem_req_addr   = addr;
        exp_err            = 1'b1;
        injected           = 1'b1;
      end
      mem.mem_rd_ready = rdy;
      @(negedge clock);
      mem.mem_req_valid = 1'b0;
      if (rdy && v) begin
        beat++;
        exp_rd++;
      end
      cyc++;
      if (!v) break;
    end
    mem.mem_rd_ready = 1'b0;
    check("rd_beat_count", 64'(beat), 64'(len + 1));
    check("rd_end_valid", mem.mem_rd_valid, 0);
    check("rd_end_busy", busy, 0);
    check("rd_err", err, exp_err);
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_rd_valid", mem.mem_rd_valid, 0);
    check("rst_rd_bits", mem.mem_rd_bits, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_err = 1'b0;
    exp_rd  = 0;
    exp_wr  = 0;
    check_stats();
  endtask

  initial begin
    logic [63:0] a;
    int          len;
    n_checks = 0;
    n_errors = 0;
    exp_err  = 1'b0;
    exp_rd   = 0;
    exp_wr   = 0;
    mem.mem_req_valid  = 1'b0;
    mem.mem_req_opcode = 1'b0;
    mem.mem_req_len    = '0;
    mem.mem_req_addr   = '0;
    mem.mem_wr_valid   = 1'b0;
    mem.mem_wr_bits    = '0;
    mem.mem_rd_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_rd_valid", mem.mem_rd_valid, 0);
    check("reset_rd_bits", mem.mem_rd_bits, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    check_stats();

    // Fill the whole SRAM with one maximum-length burst (upper/low addr bits junk)
    do_write({$urandom, 32'h0000_0000} | 64'h5, 255, 1'b0);

    // Test 1: single-beat read, latency and busy drop
    wdata_q.push_back(64'h11);
    do_write(64'h20, 0, 1'b0);
    do_read(64'h20, 0, 0, 0);

    // Test 2: 4-beat write then read with ready toggling
    pulse_reset();
    wdata_q = {64'hA, 64'hB, 64'hC, 64'hD};
    do_write(64'h0, 3, 1'b0);
    do_read(64'h0, 3, 1, 0);
    check_stats();

    // Test 3: write wraps past the last word
    wdata_q = {64'h1, 64'h2};
    do_write(64'((DEPTH - 1) * 8), 1, 1'b1);
    check("wrap_model_last", model[DEPTH-1], 64'h1);
    do_read(64'((DEPTH - 1) * 8), 1, 0, 0);
    do_read(64'h0, 0, 0, 0);

    // Randomized bursts with gaps and random ready
    for (int i = 0; i < 40; i++) begin
      a   = {$urandom, $urandom};
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, len, 1'b1);
      else                           do_read(a, len, int'($urandom_range(0, 2)), 0);
    end
    do_read({$urandom, $urandom}, 255, 2, 0);
    check_stats();

    // Test 4: request during a read burst and stray write beat in IDLE
    do_read(64'h0, 3, 0, 1);
    check("err_after_req_in_burst", err, 1);
    @(negedge clock);
    mem.mem_wr_valid = 1'b1;
    mem.mem_wr_bits  = 64'hDEAD_BEEF;
    @(negedge clock);
    mem.mem_wr_valid = 1'b0;
    check("err_sticky", err, 1);
    check("stray_busy", busy, 0);
    do_read(64'h0, 3, 2, 0);

    // Test 5: async reset mid read burst
    @(negedge clock);
    mem.mem_req_valid  = 1'b1;
    mem.mem_req_opcode = 1'b0;
    mem.mem_req_len    = LEN_BITS'(7);
    mem.mem_req_addr   = 64'h40;
    @(negedge clock);
    mem.mem_req_valid  = 1'b0;
    repeat (RD_LAT) @(negedge clock);
    check("mid_rd_valid", mem.mem_rd_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rd_valid", mem.mem_rd_valid, 0);
    check("async_busy", busy, 0);
    check("async_err", err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_err = 1'b0;
    exp_rd  = 0;
    exp_wr  = 0;
    mem.mem_rd_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("abandoned_no_beats", mem.mem_rd_valid, 0);
    end
    mem.mem_rd_ready = 1'b0;
    do_read(64'h40, 7, 2, 0);
    check_stats();

    // Request landing on the final-beat handshake is also dropped
    pulse_reset();
    do_read(64'h18, 2, 0, 2);
    check("err_final_beat_req", err, 1);
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
